// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: bundles the decode-side fields, the forwarding sources
// and the ALU-facing results of the ID/EX operand stage.
interface ex_operand_stage_if #(
    parameter int XLEN = 64,
    parameter int REGW = 5
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_alu_src;
    logic [3:0]      id_alu_op;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_branch;
    logic [REGW-1:0] exm_rd;
    logic            exm_reg_write;
    logic [XLEN-1:0] exm_result;
    logic [REGW-1:0] wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_result;
    logic            load_use_hazard;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic            ex_valid;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic [XLEN-1:0] ex_store_data;

    // upstream pipeline / test driver side
    modport master (
        output stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_alu_op, id_rs1, id_rs2, id_rd, id_reg_write,
               id_mem_read, id_mem_write, id_branch, exm_rd, exm_reg_write,
               exm_result, wb_rd, wb_reg_write, wb_result,
        input  load_use_hazard, alu_a, alu_b, alu_op, ex_valid, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_store_data
    );

    // operand stage side
    modport slave (
        input  stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_alu_op, id_rs1, id_rs2, id_rd, id_reg_write,
               id_mem_read, id_mem_write, id_branch, exm_rd, exm_reg_write,
               exm_result, wb_rd, wb_reg_write, wb_result,
        output load_use_hazard, alu_a, alu_b, alu_op, ex_valid, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_store_data
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand
// forwarding and load-use bubble insertion, feeding the ALU directly.
module ex_operand_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic               clk,
    input  logic               reset,
    ex_operand_stage_if.slave  bus
);
    logic            valid_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic            alu_src_q;
    logic [3:0]      alu_op_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [REGW-1:0] rd_q;
    logic            reg_write_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic            branch_q;
    logic            hazard;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // A load in EX whose destination is read by the decode slot cannot be
    // forwarded in time, so decode holds and EX takes a bubble instead.
    // rs2 only matters when it is really read: as ALU operand or store data.
    always_comb begin
        hazard = 1'b0;
        if (valid_q && mem_read_q && (rd_q != '0) && bus.id_valid) begin
            if (rd_q == bus.id_rs1)
                hazard = 1'b1;
            else if ((rd_q == bus.id_rs2) && (!bus.id_alu_src || bus.id_mem_write))
                hazard = 1'b1;
        end
    end

    // ID/EX register: reset, then flush bubble, then hold, then hazard bubble
    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.stall && hazard)) begin
            valid_q     <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= 4'b0000;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else if (!bus.stall) begin
            valid_q     <= bus.id_valid;
            rs1_data_q  <= bus.id_rs1_data;
            rs2_data_q  <= bus.id_rs2_data;
            imm_q       <= bus.id_imm;
            alu_src_q   <= bus.id_alu_src;
            alu_op_q    <= bus.id_alu_op;
            rs1_q       <= bus.id_rs1;
            rs2_q       <= bus.id_rs2;
            rd_q        <= bus.id_rd;
            reg_write_q <= bus.id_reg_write;
            mem_read_q  <= bus.id_mem_read;
            mem_write_q <= bus.id_mem_write;
            branch_q    <= bus.id_branch;
        end
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 is never
    // forwarded because its architectural value is always the register file's.
    always_comb begin
        fwd_a = rs1_data_q;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == rs1_q))
            fwd_a = bus.exm_result;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == rs1_q))
            fwd_a = bus.wb_result;

        fwd_b = rs2_data_q;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == rs2_q))
            fwd_b = bus.exm_result;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == rs2_q))
            fwd_b = bus.wb_result;
    end

    assign bus.load_use_hazard = hazard;
    assign bus.alu_a           = fwd_a;
    assign bus.alu_b           = alu_src_q ? imm_q : fwd_b;
    assign bus.ex_store_data   = fwd_b;
    assign bus.alu_op          = alu_op_q;
    assign bus.ex_valid        = valid_q;
    assign bus.ex_rd           = rd_q;
    assign bus.ex_reg_write    = reg_write_q & valid_q;
    assign bus.ex_mem_read     = mem_read_q & valid_q;
    assign bus.ex_mem_write    = mem_write_q & valid_q;
    assign bus.ex_branch       = branch_q & valid_q;
endmodule
